gesture_cmd_receiver: RTL

//   Serial front end of the car datapath. Receives 8N1 UART bytes from the gesture-sensor link.

---
 rtl/gesture_cmd_receiver_pkg.sv | 40 ++++
 rtl/gesture_cmd_receiver_if.sv | 19 +
 rtl/gesture_cmd_receiver_uart_rx_byte.sv | 126 ++++++++++++
 rtl/gesture_cmd_receiver.sv | 87 ++++++++
 4 files changed

// File: rtl/gesture_cmd_receiver_pkg.sv
// Shared command encodings, RX FSM states and the byte acceptance rule.
package gesture_cmd_receiver_pkg;

  // Speed field codes, cmd[3:2]
  localparam logic [1:0] SPD_STOP   = 2'b00;
  localparam logic [1:0] SPD_NORMAL = 2'b01;
  localparam logic [1:0] SPD_FAST   = 2'b10;

  // Steer field codes, cmd[1:0]
  localparam logic [1:0] STR_STRAIGHT = 2'b00;
  localparam logic [1:0] STR_RIGHT    = 2'b01;
  localparam logic [1:0] STR_LEFT     = 2'b10;

  // Both fields use 2'b11 as the one unassigned (illegal) code
  localparam logic [1:0] FIELD_ILLEGAL = 2'b11;

  localparam logic [3:0] CMD_STOP = {SPD_STOP, STR_STRAIGHT};

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // High nibble carries the bitwise complement of the command nibble
  function automatic logic byte_intact(input logic [7:0] b);
    return b[7:4] == ~b[3:0];
  endfunction

  function automatic logic byte_legal(input logic [7:0] b);
    return (b[3:2] != FIELD_ILLEGAL) && (b[1:0] != FIELD_ILLEGAL);
  endfunction

  // A byte is accepted only if it is intact and carries legal fields
  function automatic logic byte_ok(input logic [7:0] b);
    return byte_intact(b) && byte_legal(b);
  endfunction

endpackage

// File: rtl/gesture_cmd_receiver_if.sv
// Serial link in, command and status out. The receiver sits on the slave side.
interface gesture_cmd_receiver_if;
  logic       uart_rx;
  logic [3:0] cmd_nibble;
  logic       cmd_valid;
  logic       frame_err;
  logic       check_err;
  logic       link_lost;

  modport master (
    output uart_rx,
    input  cmd_nibble, cmd_valid, frame_err, check_err, link_lost
  );

  modport slave (
    input  uart_rx,
    output cmd_nibble, cmd_valid, frame_err, check_err, link_lost
  );
endinterface

// File: rtl/gesture_cmd_receiver_uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, mid-bit sampling timer, RX FSM and
// LSB-first shift register. byte_done/frame_err are registered pulses that
// appear the cycle after the stop-bit sample.
module uart_rx_byte
  import gesture_cmd_receiver_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 13020
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_done,
  output logic       frame_err
);

  localparam int unsigned   TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);

  logic            sync1_q, sync1_d;
  logic            rx_s_q, rx_s_d;
  logic            rx_prev_q, rx_prev_d;
  rx_state_t       state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_done_q, byte_done_d;
  logic            frame_err_q, frame_err_d;

  logic tick;
  logic fall;

  assign tick = (timer_q == '0);
  // rx_prev tracks rx_s continuously, so a line held low never looks like a new edge
  assign fall = rx_prev_q & ~rx_s_q;

  // Synchroniser and edge-history next values
  always_comb begin
    sync1_d   = rx;
    rx_s_d    = sync1_q;
    rx_prev_d = rx_s_q;
  end

  // State register plus all datapath flops; sync chain resets to the idle level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= RX_IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      byte_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      rx_s_q      <= rx_s_d;
      rx_prev_q   <= rx_prev_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_done_q <= byte_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state: start on a falling edge, reject a start bit that is high at mid-bit
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (fall) state_d = RX_START;
      RX_START: if (tick) state_d = rx_s_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && (bit_cnt_q == 3'd7)) state_d = RX_STOP;
      RX_STOP:  if (tick) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  // Outputs/datapath: bit timer reload, sampling into the shift register, stop check
  always_comb begin
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_done_d = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (fall) timer_d = HALF_LOAD;
      end
      RX_START: begin
        if (tick) begin
          timer_d   = FULL_LOAD;
          bit_cnt_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      RX_DATA: begin
        if (tick) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          timer_d   = FULL_LOAD;
          bit_cnt_d = bit_cnt_q + 3'd1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      RX_STOP: begin
        if (tick) begin
          byte_done_d = rx_s_q;
          frame_err_d = ~rx_s_q;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: ;
    endcase
  end

  assign byte_data = shift_q;
  assign byte_done = byte_done_q;
  assign frame_err = frame_err_q;

endmodule

// File: rtl/gesture_cmd_receiver.sv
// Gesture link front end: receives bytes, accepts intact/legal commands into
// the command register, and forces a stop when the link goes quiet.
module gesture_cmd_receiver
  import gesture_cmd_receiver_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 125_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned TIMEOUT_MS = 250
) (
  input  logic                   clk,
  input  logic                   reset,
  gesture_cmd_receiver_if.slave  bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned TIMEOUT_CYC  = (CLK_HZ / 1000) * TIMEOUT_MS;
  localparam int unsigned WDW          = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WDW-1:0] WD_MAX    = WDW'(TIMEOUT_CYC);

  logic [7:0] rx_byte;
  logic       rx_done;
  logic       rx_frame_err;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (bus.uart_rx),
    .byte_data (rx_byte),
    .byte_done (rx_done),
    .frame_err (rx_frame_err)
  );

  logic [3:0]     cmd_q, cmd_d;
  logic           cmd_valid_q, cmd_valid_d;
  logic           check_err_q, check_err_d;
  logic           link_lost_q, link_lost_d;
  logic [WDW-1:0] wd_q, wd_d;

  logic           ok;
  logic           accept;
  logic [WDW-1:0] wd_inc;

  assign ok     = byte_ok(rx_byte);
  assign accept = rx_done & ok;

  // Acceptance beats watchdog expiry when both land on the same cycle
  always_comb begin
    wd_inc      = (wd_q == WD_MAX) ? wd_q : wd_q + WDW'(1);
    cmd_d       = cmd_q;
    link_lost_d = link_lost_q;
    wd_d        = wd_inc;
    cmd_valid_d = accept;
    check_err_d = rx_done & ~ok;
    if (accept) begin
      cmd_d       = rx_byte[3:0];
      wd_d        = '0;
      link_lost_d = 1'b0;
    end else if (wd_inc == WD_MAX) begin
      cmd_d       = CMD_STOP;
      link_lost_d = 1'b1;
    end
  end

  // Command register, status pulses and watchdog; the link counts as lost out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q       <= CMD_STOP;
      cmd_valid_q <= 1'b0;
      check_err_q <= 1'b0;
      link_lost_q <= 1'b1;
      wd_q        <= '0;
    end else begin
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      check_err_q <= check_err_d;
      link_lost_q <= link_lost_d;
      wd_q        <= wd_d;
    end
  end

  assign bus.cmd_nibble = cmd_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.check_err  = check_err_q;
  assign bus.frame_err  = rx_frame_err;
  assign bus.link_lost  = link_lost_q;

endmodule
